// File: rtl/sum_stage_ctrl_pkg.sv
// Shared types and constants for the PE partial-sum accumulation stage controller.
// Provides the controller state encoding, default counter widths and the
// latched per-pass configuration record.
package sum_stage_ctrl_pkg;

   localparam int SumAccCntWd = 8;
   localparam int SumPixCntWd = 6;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ACC   = 3'd1,
      MERGE = 3'd2,
      FWD   = 3'd3,
      DONE  = 3'd4
   } sum_ctrl_state_t;

   // Stored field widths follow the package constants; the top-level width
   // parameters default to these and are expected to match them.
   typedef struct packed {
      logic [SumAccCntWd-1:0] acc_num;
      logic [SumPixCntWd-1:0] pix_num;
      logic                   use_psum;
   } sum_ctrl_cfg_t;

endpackage

// File: rtl/sum_ctrl_cnt.sv
// Loadable up-counter with a terminal-count flag; a limit of 0 counts as 1.
// Ports: clk_i, rst_ni (async active-low), clr_i (sync zero), inc_i (advance),
//        num_i (configured count), cnt_o (current value), last_o (at final value).
module sum_ctrl_cnt #(
   parameter int Wd = 8
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clr_i,
   input  logic          inc_i,
   input  logic [Wd-1:0] num_i,
   output logic [Wd-1:0] cnt_o,
   output logic          last_o
);

   logic [Wd-1:0] cnt_q;
   logic [Wd-1:0] cnt_d;
   logic [Wd-1:0] last_val;

   // Saturate 0 to 1 before taking the terminal value, so a zero config
   // behaves exactly like a one.
   assign last_val = (num_i == '0) ? '0 : (num_i - Wd'(1));
   assign last_o   = (cnt_q == last_val);
   assign cnt_o    = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         // Returning to zero on the final count keeps the value inside the
         // configured range.
         cnt_d = last_o ? '0 : (cnt_q + Wd'(1));
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sum_stage_ctrl.sv
// Sequencer for a PE partial-sum stage: counts sum beats per pixel, optionally
// merges an upstream psum, forwards each pixel result, and pulses o_done per pass.
// Ports: i_cfg_* pass config handshake; i_sum/i_psum/o_out valid-ready triplets;
//        o_cont_* stage controls (combinational); i_soft_clr sync abort; o_done.
// Optional: SUM_STAGE_CTRL_PERF_EN adds o_stall_cnt, a saturating 16-bit count of
//           stall cycles in ACC/MERGE/FWD, cleared on config accept.
module sum_stage_ctrl
   import sum_stage_ctrl_pkg::*;
#(
   parameter int AccCntWd = SumAccCntWd,
   parameter int PixCntWd = SumPixCntWd
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_cfg_valid,
   output logic                o_cfg_ready,
   input  logic [AccCntWd-1:0] i_cfg_acc_num,
   input  logic [PixCntWd-1:0] i_cfg_pix_num,
   input  logic                i_cfg_use_psum,
   input  logic                i_soft_clr,
   input  logic                i_sum_valid,
   output logic                o_sum_ready,
   input  logic                i_psum_valid,
   output logic                o_psum_ready,
   output logic                o_out_valid,
   input  logic                i_out_ready,
   output logic                o_cont_reset,
   output logic                o_cont_stall,
   output logic                o_cont_first_pix,
   output logic                o_cont_read_psum,
   output logic                o_cont_forward,
   output logic                o_done
`ifdef SUM_STAGE_CTRL_PERF_EN
   ,
   output logic [15:0]         o_stall_cnt
`endif
);

   sum_ctrl_state_t state_q, state_d;
   sum_ctrl_cfg_t   cfg_q, cfg_d;

   logic                acc_clr, acc_inc, acc_last;
   logic                pix_clr, pix_inc, pix_last;
   logic [AccCntWd-1:0] acc_cnt;
   // Pixel index itself is not needed here; only its terminal flag is.
   logic [PixCntWd-1:0] pix_cnt_unused;

   sum_ctrl_cnt #(.Wd(AccCntWd)) u_acc_cnt (
      .clk_i  (i_clk),
      .rst_ni (i_rst_n),
      .clr_i  (acc_clr),
      .inc_i  (acc_inc),
      .num_i  (cfg_q.acc_num),
      .cnt_o  (acc_cnt),
      .last_o (acc_last)
   );

   sum_ctrl_cnt #(.Wd(PixCntWd)) u_pix_cnt (
      .clk_i  (i_clk),
      .rst_ni (i_rst_n),
      .clr_i  (pix_clr),
      .inc_i  (pix_inc),
      .num_i  (cfg_q.pix_num),
      .cnt_o  (pix_cnt_unused),
      .last_o (pix_last)
   );

   always_comb begin
      state_d          = state_q;
      cfg_d            = cfg_q;
      acc_clr          = 1'b0;
      acc_inc          = 1'b0;
      pix_clr          = 1'b0;
      pix_inc          = 1'b0;
      o_cfg_ready      = 1'b0;
      o_sum_ready      = 1'b0;
      o_psum_ready     = 1'b0;
      o_out_valid      = 1'b0;
      o_cont_reset     = 1'b0;
      o_cont_stall     = 1'b0;
      o_cont_first_pix = 1'b0;
      o_cont_read_psum = 1'b0;
      o_cont_forward   = 1'b0;
      o_done           = 1'b0;

      if (i_soft_clr) begin
         // Abort wins over everything: every handshake is closed this cycle so
         // no beat, psum or result is consumed, and a pending config is refused.
         state_d      = IDLE;
         acc_clr      = 1'b1;
         pix_clr      = 1'b1;
         o_cont_reset = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               o_cfg_ready = 1'b1;
               if (i_cfg_valid) begin
                  cfg_d.acc_num  = i_cfg_acc_num;
                  cfg_d.pix_num  = i_cfg_pix_num;
                  cfg_d.use_psum = i_cfg_use_psum;
                  acc_clr        = 1'b1;
                  pix_clr        = 1'b1;
                  o_cont_reset   = 1'b1;
                  state_d        = ACC;
               end
            end
            ACC: begin
               o_sum_ready  = 1'b1;
               o_cont_stall = !i_sum_valid;
               if (i_sum_valid) begin
                  o_cont_first_pix = (acc_cnt == '0);
                  acc_inc          = 1'b1;
                  if (acc_last) begin
                     state_d = cfg_q.use_psum ? MERGE : FWD;
                  end
               end
            end
            MERGE: begin
               o_psum_ready     = 1'b1;
               o_cont_read_psum = i_psum_valid;
               o_cont_stall     = !i_psum_valid;
               if (i_psum_valid) begin
                  state_d = FWD;
               end
            end
            FWD: begin
               o_out_valid    = 1'b1;
               o_cont_forward = 1'b1;
               o_cont_stall   = !i_out_ready;
               if (i_out_ready) begin
                  if (pix_last) begin
                     state_d = DONE;
                  end else begin
                     pix_inc = 1'b1;
                     state_d = ACC;
                  end
               end
            end
            DONE: begin
               o_done  = 1'b1;
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         cfg_q   <= '0;
      end else begin
         state_q <= state_d;
         cfg_q   <= cfg_d;
      end
   end

`ifdef SUM_STAGE_CTRL_PERF_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic        cfg_accept;

   assign cfg_accept  = (state_q == IDLE) && i_cfg_valid && !i_soft_clr;
   assign o_stall_cnt = stall_cnt_q;

   // o_cont_stall is only ever raised in ACC/MERGE/FWD, so it doubles as the
   // state qualifier.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (cfg_accept) begin
         stall_cnt_d = '0;
      end else if (o_cont_stall && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_sum_stage_ctrl.sv
// Directed bench for sum_stage_ctrl: cycle-indexed traces of the control
// outputs compared against hand-derived bit patterns per scenario.
module tb_sum_stage_ctrl;

   logic       i_clk;
   logic       i_rst_n;
   logic       i_cfg_valid;
   logic       o_cfg_ready;
   logic [7:0] i_cfg_acc_num;
   logic [5:0] i_cfg_pix_num;
   logic       i_cfg_use_psum;
   logic       i_soft_clr;
   logic       i_sum_valid;
   logic       o_sum_ready;
   logic       i_psum_valid;
   logic       o_psum_ready;
   logic       o_out_valid;
   logic       i_out_ready;
   logic       o_cont_reset;
   logic       o_cont_stall;
   logic       o_cont_first_pix;
   logic       o_cont_read_psum;
   logic       o_cont_forward;
   logic       o_done;
`ifdef SUM_STAGE_CTRL_PERF_EN
   logic [15:0] o_stall_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   sum_stage_ctrl dut (
      .i_clk            (i_clk),
      .i_rst_n          (i_rst_n),
      .i_cfg_valid      (i_cfg_valid),
      .o_cfg_ready      (o_cfg_ready),
      .i_cfg_acc_num    (i_cfg_acc_num),
      .i_cfg_pix_num    (i_cfg_pix_num),
      .i_cfg_use_psum   (i_cfg_use_psum),
      .i_soft_clr       (i_soft_clr),
      .i_sum_valid      (i_sum_valid),
      .o_sum_ready      (o_sum_ready),
      .i_psum_valid     (i_psum_valid),
      .o_psum_ready     (o_psum_ready),
      .o_out_valid      (o_out_valid),
      .i_out_ready      (i_out_ready),
      .o_cont_reset     (o_cont_reset),
      .o_cont_stall     (o_cont_stall),
      .o_cont_first_pix (o_cont_first_pix),
      .o_cont_read_psum (o_cont_read_psum),
      .o_cont_forward   (o_cont_forward),
      .o_done           (o_done)
`ifdef SUM_STAGE_CTRL_PERF_EN
      ,
      .o_stall_cnt      (o_stall_cnt)
`endif
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   function automatic logic [9:0] out_vec();
      return {o_cfg_ready, o_sum_ready, o_psum_ready, o_out_valid, o_cont_reset,
              o_cont_stall, o_cont_first_pix, o_cont_read_psum, o_cont_forward, o_done};
   endfunction

   task automatic idle_inputs();
      i_cfg_valid    = 1'b0;
      i_cfg_acc_num  = '0;
      i_cfg_pix_num  = '0;
      i_cfg_use_psum = 1'b0;
      i_soft_clr     = 1'b0;
      i_sum_valid    = 1'b0;
      i_psum_valid   = 1'b0;
      i_out_ready    = 1'b0;
   endtask

   task automatic test_reset();
      logic [9:0] v;
      idle_inputs();
      i_rst_n = 1'b0;
      #1;
      v = out_vec();
      n_tests++;
      if (v !== 10'b10_0000_0000) begin
         $display("FAIL reset_outputs: got %b expected %b", v, 10'b10_0000_0000);
         n_fail++;
      end
      #1 i_rst_n = 1'b1;
      @(posedge i_clk); #1;
   endtask

   // acc=3 pix=2 no psum, sum_valid and out_ready held high.
   task automatic test_basic();
      logic [15:0] fp, fw, dn, st, sr, cr;
      fp = '0; fw = '0; dn = '0; st = '0; sr = '0; cr = '0;
      i_cfg_acc_num = 8'd3; i_cfg_pix_num = 6'd2; i_cfg_use_psum = 1'b0;
      i_sum_valid = 1'b1; i_out_ready = 1'b1;
      for (int c = 0; c < 11; c++) begin
         i_cfg_valid = (c == 0);
         @(negedge i_clk);
         fp[c] = o_cont_first_pix; fw[c] = o_cont_forward; dn[c] = o_done;
         st[c] = o_cont_stall; sr[c] = o_sum_ready; cr[c] = o_cfg_ready;
         if (c == 0) begin
            n_tests++;
            if (o_cont_reset !== 1'b1) begin
               $display("FAIL basic_cfg_reset: got %b expected 1", o_cont_reset);
               n_fail++;
            end
         end
         @(posedge i_clk); #1;
      end
      n_tests++;
      if (fp !== 16'h0022) begin $display("FAIL basic_first_pix: got %h expected %h", fp, 16'h0022); n_fail++; end
      n_tests++;
      if (fw !== 16'h0110) begin $display("FAIL basic_forward: got %h expected %h", fw, 16'h0110); n_fail++; end
      n_tests++;
      if (dn !== 16'h0200) begin $display("FAIL basic_done: got %h expected %h", dn, 16'h0200); n_fail++; end
      n_tests++;
      if (st !== 16'h0000) begin $display("FAIL basic_stall: got %h expected %h", st, 16'h0000); n_fail++; end
      n_tests++;
      if (sr !== 16'h00EE) begin $display("FAIL basic_sum_ready: got %h expected %h", sr, 16'h00EE); n_fail++; end
      n_tests++;
      if (cr !== 16'h0401) begin $display("FAIL basic_cfg_ready: got %h expected %h", cr, 16'h0401); n_fail++; end
      idle_inputs();
   endtask

   // acc=2 pix=1 with psum merge; psum_valid withheld for the first 3 MERGE cycles.
   task automatic test_psum();
      logic [15:0] st, rp, pr, fw, dn;
      logic [15:0] sc;
      st = '0; rp = '0; pr = '0; fw = '0; dn = '0; sc = '0;
      i_cfg_acc_num = 8'd2; i_cfg_pix_num = 6'd1; i_cfg_use_psum = 1'b1;
      i_sum_valid = 1'b1; i_out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         i_cfg_valid  = (c == 0);
         i_psum_valid = (c >= 6);
         @(negedge i_clk);
         st[c] = o_cont_stall; rp[c] = o_cont_read_psum; pr[c] = o_psum_ready;
         fw[c] = o_cont_forward; dn[c] = o_done;
`ifdef SUM_STAGE_CTRL_PERF_EN
         if (c == 8) sc = o_stall_cnt;
`endif
         @(posedge i_clk); #1;
      end
      n_tests++;
      if (st !== 16'h0038) begin $display("FAIL psum_stall: got %h expected %h", st, 16'h0038); n_fail++; end
      n_tests++;
      if (rp !== 16'h0040) begin $display("FAIL psum_read: got %h expected %h", rp, 16'h0040); n_fail++; end
      n_tests++;
      if (pr !== 16'h0078) begin $display("FAIL psum_ready: got %h expected %h", pr, 16'h0078); n_fail++; end
      n_tests++;
      if (fw !== 16'h0080) begin $display("FAIL psum_forward: got %h expected %h", fw, 16'h0080); n_fail++; end
      n_tests++;
      if (dn !== 16'h0100) begin $display("FAIL psum_done: got %h expected %h", dn, 16'h0100); n_fail++; end
`ifdef SUM_STAGE_CTRL_PERF_EN
      n_tests++;
      if (sc !== 16'd3) begin $display("FAIL perf_stall_cnt: got %0d expected 3", sc); n_fail++; end
`endif
      idle_inputs();
   endtask

   // acc=1 pix=2; first FWD sees out_ready low for 4 cycles.
   task automatic test_fwd_stall();
      logic [15:0] ov, st, fw, dn, fp;
      ov = '0; st = '0; fw = '0; dn = '0; fp = '0;
      i_cfg_acc_num = 8'd1; i_cfg_pix_num = 6'd2; i_cfg_use_psum = 1'b0;
      i_sum_valid = 1'b1;
      for (int c = 0; c < 11; c++) begin
         i_cfg_valid = (c == 0);
         i_out_ready = !(c >= 2 && c <= 5);
         @(negedge i_clk);
         ov[c] = o_out_valid; st[c] = o_cont_stall; fw[c] = o_cont_forward;
         dn[c] = o_done; fp[c] = o_cont_first_pix;
         @(posedge i_clk); #1;
      end
      n_tests++;
      if (ov !== 16'h017C) begin $display("FAIL fwd_out_valid: got %h expected %h", ov, 16'h017C); n_fail++; end
      n_tests++;
      if (st !== 16'h003C) begin $display("FAIL fwd_stall: got %h expected %h", st, 16'h003C); n_fail++; end
      n_tests++;
      if (fw !== 16'h017C) begin $display("FAIL fwd_forward: got %h expected %h", fw, 16'h017C); n_fail++; end
      n_tests++;
      if (dn !== 16'h0200) begin $display("FAIL fwd_done: got %h expected %h", dn, 16'h0200); n_fail++; end
      n_tests++;
      if (fp !== 16'h0082) begin $display("FAIL fwd_first_pix: got %h expected %h", fp, 16'h0082); n_fail++; end
      idle_inputs();
   endtask

   // Zero config counts behave as 1/1.
   task automatic test_zero_cfg();
      logic [15:0] fp, fw, dn, cr;
      fp = '0; fw = '0; dn = '0; cr = '0;
      i_cfg_acc_num = 8'd0; i_cfg_pix_num = 6'd0; i_cfg_use_psum = 1'b0;
      i_sum_valid = 1'b1; i_out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         i_cfg_valid = (c == 0);
         @(negedge i_clk);
         fp[c] = o_cont_first_pix; fw[c] = o_cont_forward; dn[c] = o_done; cr[c] = o_cfg_ready;
         @(posedge i_clk); #1;
      end
      n_tests++;
      if (fp !== 16'h0002) begin $display("FAIL zero_first_pix: got %h expected %h", fp, 16'h0002); n_fail++; end
      n_tests++;
      if (fw !== 16'h0004) begin $display("FAIL zero_forward: got %h expected %h", fw, 16'h0004); n_fail++; end
      n_tests++;
      if (dn !== 16'h0008) begin $display("FAIL zero_done: got %h expected %h", dn, 16'h0008); n_fail++; end
      n_tests++;
      if (cr !== 16'h0011) begin $display("FAIL zero_cfg_ready: got %h expected %h", cr, 16'h0011); n_fail++; end
      idle_inputs();
   endtask

   // acc=4: soft clear after 2 beats, then soft clear together with a config in IDLE.
   task automatic test_soft_clr();
      logic [15:0] rs, sr, cr, dn;
      rs = '0; sr = '0; cr = '0; dn = '0;
      i_cfg_acc_num = 8'd4; i_cfg_pix_num = 6'd1; i_cfg_use_psum = 1'b0;
      i_sum_valid = 1'b1; i_out_ready = 1'b1;
      for (int c = 0; c < 11; c++) begin
         i_cfg_valid = (c == 0) || (c == 9);
         i_soft_clr  = (c == 3) || (c == 9);
         @(negedge i_clk);
         rs[c] = o_cont_reset; sr[c] = o_sum_ready; cr[c] = o_cfg_ready; dn[c] = o_done;
         @(posedge i_clk); #1;
      end
      n_tests++;
      if (rs !== 16'h0209) begin $display("FAIL clr_cont_reset: got %h expected %h", rs, 16'h0209); n_fail++; end
      n_tests++;
      if (sr !== 16'h0006) begin $display("FAIL clr_sum_ready: got %h expected %h", sr, 16'h0006); n_fail++; end
      n_tests++;
      if (cr !== 16'h05F1) begin $display("FAIL clr_cfg_ready: got %h expected %h", cr, 16'h05F1); n_fail++; end
      n_tests++;
      if (dn !== 16'h0000) begin $display("FAIL clr_done: got %h expected %h", dn, 16'h0000); n_fail++; end
      idle_inputs();
   endtask

   // Async reset asserted while FWD holds a result with out_ready low.
   task automatic test_async_reset();
      logic [9:0] v;
      i_cfg_acc_num = 8'd1; i_cfg_pix_num = 6'd1; i_cfg_use_psum = 1'b0;
      i_sum_valid = 1'b1; i_out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         i_cfg_valid = (c == 0);
         @(negedge i_clk);
         if (c == 2) begin
            n_tests++;
            if (o_out_valid !== 1'b1) begin
               $display("FAIL arst_pre_fwd: got %b expected 1", o_out_valid);
               n_fail++;
            end
            #1 i_rst_n = 1'b0;
            #1;
            v = out_vec();
            n_tests++;
            if (v !== 10'b10_0000_0000) begin
               $display("FAIL arst_outputs: got %b expected %b", v, 10'b10_0000_0000);
               n_fail++;
            end
            #1 i_rst_n = 1'b1;
         end
         @(posedge i_clk); #1;
      end
      i_cfg_valid = 1'b0;
      @(negedge i_clk);
      v = out_vec();
      n_tests++;
      if (v !== 10'b10_0000_0000) begin
         $display("FAIL arst_idle_after: got %b expected %b", v, 10'b10_0000_0000);
         n_fail++;
      end
      @(posedge i_clk); #1;
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_psum();
      test_fwd_stall();
      test_zero_cfg();
      test_soft_clr();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sum_stage_ctrl.md
Name: sum_stage_ctrl

Overview:
- Sequencer for a PE's partial-sum accumulation stage.
- Counts accumulation beats per output pixel and decides when the stage clears, loads or merges an upstream psum, and forwards the result downstream.
- Drives the stage's i_cont_* controls and owns the three valid/ready handshakes around it: sum in, psum in, psum out.
- Sits between the PE config/top controller and the sum stage, one instance per PE.

Parameters:
- AccCntWd, 8, width of accumulation-beat count config.
- PixCntWd, 6, width of pixels-per-pass count config.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_cfg_valid  in  1  pass config valid.
- o_cfg_ready  out  1  controller idle, config accepted.
- i_cfg_acc_num  in  AccCntWd  sum beats per pixel (0 treated as 1).
- i_cfg_pix_num  in  PixCntWd  pixels per pass (0 treated as 1).
- i_cfg_use_psum  in  1  merge upstream psum before forwarding.
- i_soft_clr  in  1  synchronous abort.
- i_sum_valid  in  1  adder-tree sum beat valid.
- o_sum_ready  out  1  sum beat accepted.
- i_psum_valid  in  1  upstream psum valid.
- o_psum_ready  out  1  upstream psum accepted.
- o_out_valid  out  1  downstream psum valid.
- i_out_ready  in  1  downstream ready.
- o_cont_reset  out  1  clear stage accumulator.
- o_cont_stall  out  1  hold stage register.
- o_cont_first_pix  out  1  first beat of pixel: load, don't add.
- o_cont_read_psum  out  1  add upstream psum this cycle.
- o_cont_forward  out  1  select accumulator onto output.
- o_done  out  1  one-cycle pulse at pass end.

Behaviour:
- Reset (async, i_rst_n=0): state IDLE, counters 0, config registers 0, all outputs 0 except o_cfg_ready=1. Reset mid-operation aborts at once; no completion pulse.
- States: IDLE, ACC, MERGE, FWD, DONE. State, counters and config are registered. All o_cont_* and ready/valid outputs are combinational from state plus current handshake inputs, with zero-cycle latency.
- IDLE:
  - o_cfg_ready=1.
  - On i_cfg_valid: latch config, zero acc_cnt and pix_cnt, assert o_cont_reset for that cycle, next state ACC.
- ACC:
  - o_sum_ready=1.
  - Beat = i_sum_valid&&o_sum_ready.
  - o_cont_first_pix = beat && acc_cnt==0.
  - o_cont_stall = !i_sum_valid.
  - On beat: acc_cnt++. If acc_cnt==acc_num-1, zero acc_cnt and go to MERGE if use_psum, else FWD.
- MERGE:
  - o_psum_ready=1.
  - o_cont_read_psum = i_psum_valid.
  - o_cont_stall = !i_psum_valid.
  - On accept: next state FWD.
- FWD:
  - o_out_valid=1, o_cont_forward=1.
  - o_cont_stall = !i_out_ready.
  - o_out_valid stays high and stable until accepted.
  - On accept: if pix_cnt==pix_num-1, next state DONE; else pix_cnt++ and next state ACC.
- DONE: o_done=1 for one cycle, then IDLE.
- i_soft_clr has highest priority in any state. Next state is IDLE, counters are zeroed, and o_cont_reset=1 that cycle. All readys and valids are forced 0 that cycle, so no beat is consumed. i_soft_clr in IDLE together with i_cfg_valid rejects the config.
- Counter compares use the config value minus 1 with the 0→1 saturation applied first. No wrap past the configured count.
- acc_num=1: every beat has first_pix=1 and leaves ACC immediately.

Optional Feature:
- SUM_STAGE_CTRL_PERF_EN defined: adds o_stall_cnt (16 bit, saturating). It counts cycles with o_cont_stall=1 in ACC/MERGE/FWD, clears on config accept and on reset.
- Without the macro: the port and counter are absent; all other behaviour is identical.

Decomposition:
- PECfg package gets:
  - enum type sum_ctrl_state_t {IDLE, ACC, MERGE, FWD, DONE};
  - constants SumAccCntWd=8 and SumPixCntWd=6, used as parameter defaults.
  - packed struct sum_ctrl_cfg_t {acc_num, pix_num, use_psum}.
- One sub-module is natural: sum_ctrl_cnt, a loadable up-counter with last-flag and 0→1 saturation. It is instantiated twice, for acc and pix.

Test Plan:
- acc_num=3, pix_num=2, use_psum=0, sum_valid held 1, out_ready=1:
  - first_pix on cycles 1 and 5 after config;
  - forward on cycles 4 and 8;
  - o_done on cycle 9;
  - no stall.
- acc_num=2, pix_num=1, use_psum=1, psum_valid delayed 3 cycles: stall=1 for 3 MERGE cycles, then read_psum=1 for exactly one cycle, then forward.
- FWD with out_ready low for 4 cycles: o_out_valid stays 1, stall=1 for 4 cycles, pix_cnt unchanged; accept on cycle 5.
- acc_num=0, pix_num=0: behaves as 1/1; every beat shows first_pix=1; done after one forward.
- i_soft_clr in ACC after 2 of 4 beats: next cycle IDLE, o_cont_reset=1 in the clear cycle, no o_done, o_cfg_ready=1. i_rst_n dropped mid-FWD: all outputs 0 asynchronously.
- With SUM_STAGE_CTRL_PERF_EN, run scenario 2: o_stall_cnt=3 at o_done.
